alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter letting two requesters share one combinational ALU.
// Each operation walks IDLE -> EXEC -> RESP; the response is held until its owner takes it.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_srcA,
    input  logic [WIDTH-1:0] req0_srcB,
    input  logic [WIDTH-1:0] req1_srcA,
    input  logic [WIDTH-1:0] req1_srcB,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_srcA,
    output logic [WIDTH-1:0] alu_srcB,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] src_a_q, src_a_d;
    logic [WIDTH-1:0] src_b_q, src_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [2:0]       op_q, op_d;
    logic             zero_q, zero_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic             grant0_s, grant1_s, rsp_take_s;

    // Arbitration, operand latching, result capture and state sequencing.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        op_d         = op_q;
        res_d        = res_q;
        zero_d       = zero_q;
        grant0_s     = 1'b0;
        grant1_s     = 1'b0;
        rsp_take_s   = id_q ? rsp1_ready : rsp0_ready;

        case (state_q)
            IDLE: begin
                // On a tie the requester that did not win last time gets the ALU.
                if (req0_valid && req1_valid) begin
                    grant0_s = last_grant_q;
                    grant1_s = ~last_grant_q;
                end else begin
                    grant0_s = req0_valid;
                    grant1_s = req1_valid;
                end

                if (grant0_s) begin
                    src_a_d      = req0_srcA;
                    src_b_d      = req0_srcB;
                    op_d         = req0_op;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                end else if (grant1_s) begin
                    src_a_d      = req1_srcA;
                    src_b_d      = req1_srcB;
                    op_d         = req1_op;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_take_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rsp0_valid_d = (state_d == RESP) && !id_d;
        rsp1_valid_d = (state_d == RESP) && id_d;
    end

    // State, latched operation and held response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            src_a_q      <= '0;
            src_b_q      <= '0;
            op_q         <= 3'b000;
            res_q        <= '0;
            zero_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            op_q         <= op_d;
            res_q        <= res_d;
            zero_q       <= zero_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign req0_ready = grant0_s & ~reset;
    assign req1_ready = grant1_s & ~reset;
    assign alu_srcA   = src_a_q;
    assign alu_srcB   = src_b_q;
    assign alu_ctrl   = op_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a random run against a transaction-level model.
module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_srcA, req0_srcB, req1_srcA, req1_srcB;
    logic [2:0]   req0_op, req1_op, alu_ctrl;
    logic [W-1:0] alu_srcA, alu_srcB, alu_result, rsp_result;
    logic         alu_zero, rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, rsp_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_srcA(req0_srcA), .req0_srcB(req0_srcB),
        .req1_srcA(req1_srcA), .req1_srcB(req1_srcB),
        .req0_op(req0_op), .req1_op(req1_op),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b101:  r[0] = ($signed(a) < $signed(b));
            default: r = '0;
        endcase
        return r;
    endfunction

    // The shared ALU the arbiter drives.
    always_comb begin
        alu_result = ref_alu(alu_ctrl, alu_srcA, alu_srcB);
        alu_zero   = (alu_result == '0);
    end

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_srcA = '0; req0_srcB = '0; req1_srcA = '0; req1_srcB = '0;
        req0_op = 3'b000; req1_op = 3'b000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one operation alone and return what was observed at grant and response time.
    task automatic run_op(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic rdy, output logic vld, output logic [W-1:0] res, output logic z);
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_srcA = a; req1_srcB = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_srcA = a; req0_srcB = b;
        end
        #1;
        rdy = id ? req1_ready : req0_ready;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        #1;
        vld = id ? rsp1_valid : rsp0_valid;
        res = rsp_result;
        z   = rsp_zero;
        if (id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_req0_ready got %0b want 0", req0_ready); end
        n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_req1_ready got %0b want 0", req1_ready); end
        n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got %b want 00", {rsp0_valid, rsp1_valid}); end
        n_vec++; if (rsp_result !== '0 || rsp_zero !== 1'b0) begin n_err++; $display("FAIL reset_rsp got %h/%0b want 0/0", rsp_result, rsp_zero); end
        n_vec++; if (alu_srcA !== '0 || alu_srcB !== '0 || alu_ctrl !== 3'b000) begin n_err++; $display("FAIL reset_alu got %h %h %b want zeros", alu_srcA, alu_srcB, alu_ctrl); end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single();
        @(negedge clk);
        req0_valid = 1'b1; req0_srcA = 32'd5; req0_srcB = 32'd7; req0_op = 3'b000;
        #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        n_vec++; if (alu_srcA !== 32'd5 || alu_srcB !== 32'd7 || alu_ctrl !== 3'b000) begin n_err++; $display("FAIL single_alu_drive got %h %h %b want 5 7 000", alu_srcA, alu_srcB, alu_ctrl); end
        n_vec++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL single_early_rsp got %0b want 0", rsp0_valid); end
        @(negedge clk);
        #1;
        n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin n_err++; $display("FAIL single_rsp_valid got %b want 10", {rsp0_valid, rsp1_valid}); end
        n_vec++; if (rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin n_err++; $display("FAIL single_result got %0d/%0b want 12/0", rsp_result, rsp_zero); end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        #1;
        n_vec++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_release got %0b want 0", rsp0_valid); end
    endtask

    task automatic test_tie();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b001; req0_srcA = 32'd9;    req0_srcB = 32'd9;
        req1_valid = 1'b1; req1_op = 3'b011; req1_srcA = 32'hF0;   req1_srcB = 32'h0F;
        #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL tie_first_grant got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL tie_exec_ready got %b want 00", {req0_ready, req1_ready}); end
        @(negedge clk);
        #1;
        n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp_result !== '0 || rsp_zero !== 1'b1) begin
            n_err++; $display("FAIL tie_rsp0 got v=%b r=%h z=%0b want 10/0/1", {rsp0_valid, rsp1_valid}, rsp_result, rsp_zero); end
        rsp0_ready = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        rsp0_ready = 1'b0;
        #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL tie_back_to_back got %b want 01", {req0_ready, req1_ready}); end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp_result !== 32'hFF || rsp_zero !== 1'b0) begin
            n_err++; $display("FAIL tie_rsp1 got v=%b r=%h z=%0b want 01/ff/0", {rsp0_valid, rsp1_valid}, rsp_result, rsp_zero); end
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic e0, e1;
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_srcA = 32'd1; req0_srcB = 32'd2; req1_srcA = 32'd3; req1_srcB = 32'd4;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            e0 = (k % 3 == 0) && ((k / 3) % 2 == 0);
            e1 = (k % 3 == 0) && ((k / 3) % 2 == 1);
            n_vec++; if ({req0_ready, req1_ready} !== {e0, e1}) begin n_err++; $display("FAIL rr_grant cyc%0d got %b want %b", k, {req0_ready, req1_ready}, {e0, e1}); end
            if (k % 3 == 2) begin
                e0 = ((k / 3) % 2 == 0);
                n_vec++; if ({rsp0_valid, rsp1_valid} !== {e0, ~e0}) begin n_err++; $display("FAIL rr_rsp cyc%0d got %b want %b", k, {rsp0_valid, rsp1_valid}, {e0, ~e0}); end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 3'b011; req1_srcA = 32'h1234; req1_srcB = 32'h0FF0;
        #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL bp_grant1 got %b want 01", {req0_ready, req1_ready}); end
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b000; req0_srcA = 32'd2; req0_srcB = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rsp0_ready = i[0];
            rsp1_ready = 1'b0;
            #1;
            n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp_result !== 32'h1FF4) begin
                n_err++; $display("FAIL bp_hold cyc%0d got v=%b r=%h want 01/1ff4", i, {rsp0_valid, rsp1_valid}, rsp_result); end
            n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_no_grant cyc%0d got %0b want 0", i, req0_ready); end
        end
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;
        #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL bp_next_grant got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd5) begin n_err++; $display("FAIL bp_rsp0 got v=%0b r=%0d want 1/5", rsp0_valid, rsp_result); end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
    endtask

    task automatic test_slt_badop();
        logic rdy, vld, z;
        logic [W-1:0] res;
        run_op(1'b0, 3'b101, 32'd3, 32'd8, rdy, vld, res, z);
        n_vec++; if (rdy !== 1'b1 || vld !== 1'b1) begin n_err++; $display("FAIL slt_handshake got rdy=%0b vld=%0b want 1/1", rdy, vld); end
        n_vec++; if (res !== 32'd1 || z !== 1'b0) begin n_err++; $display("FAIL slt_result got %h/%0b want 1/0", res, z); end
        run_op(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd0, rdy, vld, res, z);
        n_vec++; if (res !== 32'd1 || vld !== 1'b1) begin n_err++; $display("FAIL slt_signed got %h vld=%0b want 1/1", res, vld); end
        run_op(1'b1, 3'b111, 32'hDEAD_BEEF, 32'h1234_5678, rdy, vld, res, z);
        n_vec++; if (res !== '0 || z !== 1'b1 || vld !== 1'b1) begin n_err++; $display("FAIL badop_result got %h/%0b vld=%0b want 0/1/1", res, z, vld); end
    endtask

    task automatic test_reset_exec();
        logic rdy, vld, z;
        logic [W-1:0] res;
        run_op(1'b0, 3'b000, 32'd5, 32'd7, rdy, vld, res, z);
        n_vec++; if (res !== 32'd12) begin n_err++; $display("FAIL rx_pre_op got %0d want 12", res); end
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b000; req0_srcA = 32'd1; req0_srcB = 32'd2;
        #1;
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL rx_grant got %0b want 1", req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        n_vec++; if (rsp_result !== '0 || rsp_zero !== 1'b0 || alu_srcA !== '0 || alu_srcB !== '0) begin
            n_err++; $display("FAIL rx_async_clear got r=%h z=%0b a=%h b=%h want zeros", rsp_result, rsp_zero, alu_srcA, alu_srcB); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_vec++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL rx_no_rsp cyc%0d got %b want 00", i, {rsp0_valid, rsp1_valid}); end
        end
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL rx_tie got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
    endtask

    task automatic test_random();
        bit           m_busy, m_id, m_last;
        int           m_wait, winner;
        logic [W-1:0] m_res;
        logic         e_r0, e_r1, e_v0, e_v1;
        do_reset();
        m_busy = 1'b0; m_id = 1'b0; m_last = 1'b1; m_wait = 0; m_res = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req0_valid = ($urandom_range(0, 99) < 55);
            req1_valid = ($urandom_range(0, 99) < 55);
            req0_op = 3'($urandom_range(0, 7)); req1_op = 3'($urandom_range(0, 7));
            req0_srcA = $urandom(); req1_srcA = $urandom();
            req0_srcB = ($urandom_range(0, 3) == 0) ? req0_srcA : $urandom();
            req1_srcB = ($urandom_range(0, 3) == 0) ? req1_srcA : $urandom();
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            #1;
            winner = -1;
            if (!m_busy) begin
                if (req0_valid && req1_valid) winner = m_last ? 0 : 1;
                else if (req0_valid) winner = 0;
                else if (req1_valid) winner = 1;
            end
            e_r0 = (winner == 0);
            e_r1 = (winner == 1);
            e_v0 = m_busy && (m_wait == 0) && !m_id;
            e_v1 = m_busy && (m_wait == 0) && m_id;
            n_vec++; if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin n_err++; $display("FAIL rand_ready cyc%0d got %b want %b", c, {req0_ready, req1_ready}, {e_r0, e_r1}); end
            n_vec++; if ({rsp0_valid, rsp1_valid} !== {e_v0, e_v1}) begin n_err++; $display("FAIL rand_rsp_valid cyc%0d got %b want %b", c, {rsp0_valid, rsp1_valid}, {e_v0, e_v1}); end
            if (e_v0 || e_v1) begin
                n_vec++; if (rsp_result !== m_res || rsp_zero !== (m_res == '0)) begin
                    n_err++; $display("FAIL rand_result cyc%0d got %h/%0b want %h/%0b", c, rsp_result, rsp_zero, m_res, (m_res == '0)); end
            end
            if (winner >= 0) begin
                m_busy = 1'b1; m_wait = 1; m_id = (winner == 1); m_last = m_id;
                m_res = m_id ? ref_alu(req1_op, req1_srcA, req1_srcB) : ref_alu(req0_op, req0_srcA, req0_srcB);
            end else if (m_busy) begin
                if (m_wait > 0) m_wait--;
                else if (m_id ? rsp1_ready : rsp0_ready) m_busy = 1'b0;
            end
        end
        @(negedge clk);
        idle_inputs();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (4) @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_round_robin();
        test_backpressure();
        test_slt_badop();
        test_reset_exec();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
